// File: rtl/reg_file_sb.sv
// Architectural register file with writeback bypass and a busy-bit scoreboard
// that holds back issue on RAW/WAW hazards against pending destinations.
module reg_file_sb #(
   parameter  int XLEN = 32,
   parameter  int NREG = 32,
   localparam int AW   = $clog2(NREG)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            wb_v_i,
   input  logic [AW-1:0]   wb_addr_i,
   input  logic [XLEN-1:0] wb_data_i,
   input  logic            iss_v_i,
   input  logic [AW-1:0]   iss_rs1_i,
   input  logic [AW-1:0]   iss_rs2_i,
   input  logic [AW-1:0]   iss_rd_i,
   input  logic            iss_wen_i,
   input  logic            stall_i,
   output logic            iss_ready_o,
   output logic            op_v_o,
   output logic [XLEN-1:0] rs1_data_o,
   output logic [XLEN-1:0] rs2_data_o
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [NREG-1:0] busy_q, busy_d;
   logic [NREG-1:0] eb;
   logic            op_v_q;
   logic [XLEN-1:0] rs1_q, rs2_q;
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic            wb_en;
   logic            hazard;
   logic            accept;

   assign wb_en = wb_v_i && (wb_addr_i != '0);

   // A writeback landing this cycle already satisfies its consumer, so it masks busy.
   always_comb begin
      eb = '0;
      for (int i = 1; i < NREG; i++) begin
         eb[i] = busy_q[i] && !(wb_v_i && (wb_addr_i == AW'(i)));
      end
   end

   assign hazard      = eb[iss_rs1_i] | eb[iss_rs2_i] | (iss_wen_i & eb[iss_rd_i]);
   assign iss_ready_o = !stall_i && !hazard;
   assign accept      = iss_v_i && iss_ready_o;

   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (iss_rs1_i != '0) begin
         rs1_val = (wb_v_i && (wb_addr_i == iss_rs1_i)) ? wb_data_i : regs_q[iss_rs1_i];
      end
      if (iss_rs2_i != '0) begin
         rs2_val = (wb_v_i && (wb_addr_i == iss_rs2_i)) ? wb_data_i : regs_q[iss_rs2_i];
      end
   end

   // Set after clear: an issuing instruction is younger than the retiring one.
   always_comb begin
      busy_d = busy_q;
      if (wb_en) begin
         busy_d[wb_addr_i] = 1'b0;
      end
      if (accept && iss_wen_i && (iss_rd_i != '0)) begin
         busy_d[iss_rd_i] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
         op_v_q <= 1'b0;
         rs1_q  <= '0;
         rs2_q  <= '0;
      end else begin
         if (wb_en) begin
            regs_q[wb_addr_i] <= wb_data_i;
         end
         busy_q <= busy_d;
         if (accept) begin
            op_v_q <= 1'b1;
            rs1_q  <= rs1_val;
            rs2_q  <= rs2_val;
         end else if (!stall_i) begin
            op_v_q <= 1'b0;
         end
      end
   end

   assign op_v_o     = op_v_q;
   assign rs1_data_o = rs1_q;
   assign rs2_data_o = rs2_q;

endmodule
